// File: rtl/shift_operand_stage.sv
// shift_operand_stage
// Registers a decoded data-processing operand into the value/amount/control
// triple consumed by the barrel shifter. Register-specified shift amounts are
// fetched from Rs through a register-file read port, which costs one cycle.
//
// Ports:
//   i_clk, i_rstn     clock (rising edge), async active-low reset
//   i_flush           synchronous flush of accepted and pending work
//   i_valid/o_ready   upstream handshake (o_ready is combinational)
//   i_op2             Rm value
//   i_shtype          ARM shift type (00 LSL, 01 LSR, 10 ASR, 11 ROR)
//   i_reg_shift       1 = amount from Rs[7:0], 0 = i_imm_shift
//   i_imm_shift       immediate shift amount
//   i_rs_addr         Rs index
//   o_rf_rden/o_rf_raddr  register-file read port (combinational)
//   i_rf_rdata        read data, valid the cycle after o_rf_rden
//   o_valid/i_ready   downstream handshake
//   o_s2, o_shiftbit, o_srcon, o_asr  registered shifter-ready outputs
//
// state | meaning
// ------+--------------------------------------------
// IDLE  | no work held, ready for a new operand
// WAIT  | Rs read outstanding, Rm/type captured
// HOLD  | output triple valid, waiting for i_ready

module shift_operand_stage #(
    parameter int N = 32
) (
    input  logic         i_clk,
    input  logic         i_rstn,
    input  logic         i_flush,
    input  logic         i_valid,
    output logic         o_ready,
    input  logic [N-1:0] i_op2,
    input  logic [1:0]   i_shtype,
    input  logic         i_reg_shift,
    input  logic [4:0]   i_imm_shift,
    input  logic [3:0]   i_rs_addr,
    output logic         o_rf_rden,
    output logic [3:0]   o_rf_raddr,
    input  logic [N-1:0] i_rf_rdata,
    output logic         o_valid,
    input  logic         i_ready,
    output logic [N-1:0] o_s2,
    output logic [4:0]   o_shiftbit,
    output logic [2:0]   o_srcon,
    output logic         o_asr
);

    localparam logic [1:0] IDLE = 2'b00;
    localparam logic [1:0] WAIT = 2'b01;
    localparam logic [1:0] HOLD = 2'b10;

    localparam logic [2:0] SRC_PASS = 3'b000;
    localparam logic [2:0] SRC_RSH  = 3'b001;
    localparam logic [2:0] SRC_LSH  = 3'b010;
    localparam logic [2:0] SRC_ROR  = 3'b011;

    logic [1:0]   state;
    logic [N-1:0] rm_q;
    logic [1:0]   shtype_q;
    logic         accept;

    // Translation source: Rm/type come from the inputs on an immediate accept
    // and from the capture registers once the Rs data returns in WAIT.
    logic [N-1:0] src_rm;
    logic [1:0]   src_type;
    logic [7:0]   src_amt;

    logic [N-1:0] nxt_s2;
    logic [4:0]   nxt_shiftbit;
    logic [2:0]   nxt_srcon;
    logic         nxt_asr;

    assign o_ready    = !i_flush && ((state == IDLE) || ((state == HOLD) && i_ready));
    assign accept     = i_valid && o_ready;
    assign o_rf_rden  = accept && i_reg_shift;
    assign o_rf_raddr = i_rs_addr;

    always_comb begin
        if (state == WAIT) begin
            src_rm   = rm_q;
            src_type = shtype_q;
            src_amt  = i_rf_rdata[7:0];
        end else begin
            src_rm   = i_op2;
            src_type = i_shtype;
            src_amt  = {3'b000, i_imm_shift};
        end
    end

    always_comb begin
        nxt_s2       = src_rm;
        nxt_shiftbit = 5'd0;
        nxt_srcon    = SRC_PASS;
        nxt_asr      = (src_type == 2'b10);
        if (src_amt != 8'd0) begin
            case (src_type)
                2'b00, 2'b01: begin
                    // Logical shifts by 32 or more clear the value; only
                    // reachable with a register-specified amount.
                    if (src_amt >= 8'd32) begin
                        nxt_s2 = '0;
                    end else begin
                        nxt_shiftbit = src_amt[4:0];
                        nxt_srcon    = (src_type == 2'b00) ? SRC_LSH : SRC_RSH;
                    end
                end
                2'b10: begin
                    // ASR is passed through untouched; a later stage applies it.
                    nxt_shiftbit = src_amt[4:0];
                end
                default: begin
                    // Rotating by a multiple of 32 is the identity.
                    nxt_shiftbit = src_amt[4:0];
                    nxt_srcon    = (src_amt[4:0] == 5'd0) ? SRC_PASS : SRC_ROR;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state      <= IDLE;
            rm_q       <= '0;
            shtype_q   <= 2'b00;
            o_valid    <= 1'b0;
            o_s2       <= '0;
            o_shiftbit <= 5'd0;
            o_srcon    <= SRC_PASS;
            o_asr      <= 1'b0;
        end else if (i_flush) begin
            state   <= IDLE;
            o_valid <= 1'b0;
        end else begin
            case (state)
                IDLE, HOLD: begin
                    if (accept && i_reg_shift) begin
                        state    <= WAIT;
                        rm_q     <= i_op2;
                        shtype_q <= i_shtype;
                        o_valid  <= 1'b0;
                    end else if (accept) begin
                        state      <= HOLD;
                        o_valid    <= 1'b1;
                        o_s2       <= nxt_s2;
                        o_shiftbit <= nxt_shiftbit;
                        o_srcon    <= nxt_srcon;
                        o_asr      <= nxt_asr;
                    end else if (state == HOLD && i_ready) begin
                        state   <= IDLE;
                        o_valid <= 1'b0;
                    end
                end
                WAIT: begin
                    state      <= HOLD;
                    o_valid    <= 1'b1;
                    o_s2       <= nxt_s2;
                    o_shiftbit <= nxt_shiftbit;
                    o_srcon    <= nxt_srcon;
                    o_asr      <= nxt_asr;
                end
                default: begin
                    state   <= IDLE;
                    o_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shift_operand_stage.sv
module tb_shift_operand_stage;

    logic        i_clk = 1'b0;
    logic        i_rstn;
    logic        i_flush;
    logic        i_valid;
    logic        o_ready;
    logic [31:0] i_op2;
    logic [1:0]  i_shtype;
    logic        i_reg_shift;
    logic [4:0]  i_imm_shift;
    logic [3:0]  i_rs_addr;
    logic        o_rf_rden;
    logic [3:0]  o_rf_raddr;
    logic [31:0] i_rf_rdata;
    logic        o_valid;
    logic        i_ready;
    logic [31:0] o_s2;
    logic [4:0]  o_shiftbit;
    logic [2:0]  o_srcon;
    logic        o_asr;

    int total = 0;
    int bad   = 0;

    shift_operand_stage #(.N(32)) dut (
        .i_clk(i_clk), .i_rstn(i_rstn), .i_flush(i_flush),
        .i_valid(i_valid), .o_ready(o_ready), .i_op2(i_op2),
        .i_shtype(i_shtype), .i_reg_shift(i_reg_shift),
        .i_imm_shift(i_imm_shift), .i_rs_addr(i_rs_addr),
        .o_rf_rden(o_rf_rden), .o_rf_raddr(o_rf_raddr),
        .i_rf_rdata(i_rf_rdata), .o_valid(o_valid), .i_ready(i_ready),
        .o_s2(o_s2), .o_shiftbit(o_shiftbit), .o_srcon(o_srcon), .o_asr(o_asr)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [31:0] s2,
                           input logic [4:0] sb, input logic [2:0] sc, input logic asr);
        chk({tag, ".valid"}, {31'd0, o_valid}, {31'd0, v});
        chk({tag, ".s2"}, o_s2, s2);
        chk({tag, ".shiftbit"}, {27'd0, o_shiftbit}, {27'd0, sb});
        chk({tag, ".srcon"}, {29'd0, o_srcon}, {29'd0, sc});
        chk({tag, ".asr"}, {31'd0, o_asr}, {31'd0, asr});
    endtask

    task automatic drive(input logic v, input logic rs, input logic [1:0] ty,
                         input logic [31:0] rm, input logic [4:0] imm, input logic [3:0] ra);
        i_valid     = v;
        i_reg_shift = rs;
        i_shtype    = ty;
        i_op2       = rm;
        i_imm_shift = imm;
        i_rs_addr   = ra;
    endtask

    initial begin
        i_rstn = 1'b0; i_flush = 1'b0; i_ready = 1'b1; i_rf_rdata = '0;
        drive(1'b0, 1'b0, 2'b00, 32'h0, 5'd0, 4'd0);
        #12;
        chk_out("reset", 1'b0, 32'h0, 5'd0, 3'b000, 1'b0);
        chk("reset.ready", {31'd0, o_ready}, 32'd1);
        chk("reset.rden", {31'd0, o_rf_rden}, 32'd0);
        tick();
        i_rstn = 1'b1;
        tick();

        // Immediate LSR #4 then back-to-back LSL #1
        drive(1'b1, 1'b0, 2'b01, 32'hF000_0000, 5'd4, 4'd0);
        #1;
        chk("imm_lsr.ready", {31'd0, o_ready}, 32'd1);
        chk("imm_lsr.rden", {31'd0, o_rf_rden}, 32'd0);
        tick();
        chk_out("imm_lsr", 1'b1, 32'hF000_0000, 5'd4, 3'b001, 1'b0);
        drive(1'b1, 1'b0, 2'b00, 32'h0000_0003, 5'd1, 4'd0);
        #1;
        chk("b2b.ready", {31'd0, o_ready}, 32'd1);
        tick();
        chk_out("imm_lsl", 1'b1, 32'h0000_0003, 5'd1, 3'b010, 1'b0);
        drive(1'b0, 1'b0, 2'b00, 32'h0, 5'd0, 4'd0);
        tick();
        chk("drain.valid", {31'd0, o_valid}, 32'd0);

        // Register ROR, A=0x24
        drive(1'b1, 1'b1, 2'b11, 32'h1234_5678, 5'd0, 4'd5);
        #1;
        chk("ror.rden", {31'd0, o_rf_rden}, 32'd1);
        chk("ror.raddr", {28'd0, o_rf_raddr}, 32'd5);
        tick();
        chk("ror.wait_valid", {31'd0, o_valid}, 32'd0);
        chk("ror.wait_ready", {31'd0, o_ready}, 32'd0);
        drive(1'b0, 1'b0, 2'b00, 32'h0, 5'd0, 4'd0);
        i_rf_rdata = 32'h0000_0124;
        tick();
        chk_out("reg_ror24", 1'b1, 32'h1234_5678, 5'd4, 3'b011, 1'b0);

        // Register ROR, A=0x40 (multiple of 32), accepted from HOLD
        drive(1'b1, 1'b1, 2'b11, 32'hCAFE_0001, 5'd0, 4'd7);
        #1;
        chk("ror40.ready", {31'd0, o_ready}, 32'd1);
        chk("ror40.rden", {31'd0, o_rf_rden}, 32'd1);
        chk("ror40.raddr", {28'd0, o_rf_raddr}, 32'd7);
        tick();
        chk("ror40.drop_valid", {31'd0, o_valid}, 32'd0);
        drive(1'b0, 1'b0, 2'b00, 32'h0, 5'd0, 4'd0);
        i_rf_rdata = 32'h0000_0040;
        tick();
        chk_out("reg_ror40", 1'b1, 32'hCAFE_0001, 5'd0, 3'b000, 1'b0);

        // Register LSL A=33 clears the value
        drive(1'b1, 1'b1, 2'b00, 32'hFFFF_FFFF, 5'd0, 4'd2);
        tick();
        drive(1'b0, 1'b0, 2'b00, 32'h0, 5'd0, 4'd0);
        i_rf_rdata = 32'h0000_0021;
        tick();
        chk_out("reg_lsl33", 1'b1, 32'h0000_0000, 5'd0, 3'b000, 1'b0);

        // Register LSR A=0 (upper Rs bits ignored) passes Rm
        drive(1'b1, 1'b1, 2'b01, 32'hA5A5_0001, 5'd0, 4'd9);
        tick();
        drive(1'b0, 1'b0, 2'b00, 32'h0, 5'd0, 4'd0);
        i_rf_rdata = 32'h0000_FF00;
        tick();
        chk_out("reg_lsr0", 1'b1, 32'hA5A5_0001, 5'd0, 3'b000, 1'b0);

        // Register LSL A=31 keeps normal mapping
        drive(1'b1, 1'b1, 2'b00, 32'h0000_0001, 5'd0, 4'd1);
        tick();
        drive(1'b0, 1'b0, 2'b00, 32'h0, 5'd0, 4'd0);
        i_rf_rdata = 32'h0000_001F;
        tick();
        chk_out("reg_lsl31", 1'b1, 32'h0000_0001, 5'd31, 3'b010, 1'b0);

        // Immediate ASR #3
        drive(1'b1, 1'b0, 2'b10, 32'h8000_0000, 5'd3, 4'd0);
        tick();
        chk_out("imm_asr", 1'b1, 32'h8000_0000, 5'd3, 3'b000, 1'b1);

        // Backpressure for 5 cycles with a pending operand
        i_ready = 1'b0;
        drive(1'b1, 1'b0, 2'b00, 32'h0000_0011, 5'd2, 4'd0);
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("bp.ready", {31'd0, o_ready}, 32'd0);
            tick();
            chk_out("bp.hold", 1'b1, 32'h8000_0000, 5'd3, 3'b000, 1'b1);
        end
        i_ready = 1'b1;
        #1;
        chk("bp.release_ready", {31'd0, o_ready}, 32'd1);
        tick();
        chk_out("bp.next", 1'b1, 32'h0000_0011, 5'd2, 3'b010, 1'b0);

        // Flush while in WAIT, read data arriving that cycle
        drive(1'b1, 1'b1, 2'b00, 32'h0000_0055, 5'd0, 4'd3);
        tick();
        chk("fl.wait_valid", {31'd0, o_valid}, 32'd0);
        drive(1'b0, 1'b0, 2'b00, 32'h0, 5'd0, 4'd0);
        i_flush = 1'b1;
        i_rf_rdata = 32'h0000_0008;
        #1;
        chk("fl.ready", {31'd0, o_ready}, 32'd0);
        tick();
        chk("fl.valid", {31'd0, o_valid}, 32'd0);
        i_flush = 1'b0;
        #1;
        chk("fl.idle_ready", {31'd0, o_ready}, 32'd1);
        tick();
        chk("fl.discard_valid", {31'd0, o_valid}, 32'd0);

        // Flush suppresses a simultaneous accept
        drive(1'b1, 1'b1, 2'b00, 32'h0000_0077, 5'd1, 4'd4);
        i_flush = 1'b1;
        #1;
        chk("flacc.ready", {31'd0, o_ready}, 32'd0);
        chk("flacc.rden", {31'd0, o_rf_rden}, 32'd0);
        tick();
        i_flush = 1'b0;
        drive(1'b0, 1'b0, 2'b00, 32'h0, 5'd0, 4'd0);
        chk("flacc.valid", {31'd0, o_valid}, 32'd0);
        tick();
        chk("flacc.valid2", {31'd0, o_valid}, 32'd0);

        // Async reset pulse while HOLD
        drive(1'b1, 1'b0, 2'b01, 32'hF000_0000, 5'd4, 4'd0);
        tick();
        drive(1'b0, 1'b0, 2'b00, 32'h0, 5'd0, 4'd0);
        chk_out("pre_rst", 1'b1, 32'hF000_0000, 5'd4, 3'b001, 1'b0);
        i_ready = 1'b0;
        #2;
        i_rstn = 1'b0;
        #1;
        chk_out("async_rst", 1'b0, 32'h0, 5'd0, 3'b000, 1'b0);
        tick();
        i_rstn = 1'b1;
        #1;
        chk("rst_rel.ready", {31'd0, o_ready}, 32'd1);
        tick();
        chk("rst_rel.valid", {31'd0, o_valid}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
